alu_seq_ctrl: RTL and testbench

- Sequencing controller for the 3-bit ALU datapath (adder, subtractor, shift-add multiplier, BCD/seven-segment display).
- On a start pulse it captures the operands and opcode, holds them stable for the datapath, and raises a one-hot init to the selected unit.
- Waits for the combinational settle time or the multiplier's done, then registers the result and sign for the display stage.
- Sits between the board switches/button and the datapath and display decoder.

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_timeout_cnt.sv | 39 +++
 rtl/alu_seq_ctrl.sv | 166 ++++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the 3-bit ALU sequencing controller:
// opcodes, one-hot unit enables and FSM state encoding.
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  localparam logic [3:0] INIT_NONE = 4'b0000;
  localparam logic [3:0] INIT_ADD  = 4'b0001;
  localparam logic [3:0] INIT_SUB  = 4'b0010;
  localparam logic [3:0] INIT_MUL  = 4'b0100;

  typedef enum logic [2:0] {
    IDLE,
    EXEC,
    SETTLE,
    WAIT_MULT,
    FAULT,
    DONE
  } state_e;

  // Reserved opcode maps to no unit at all.
  function automatic logic [3:0] op_to_init(input logic [1:0] op);
    logic [3:0] r;
    case (op)
      OP_ADD:  r = INIT_ADD;
      OP_SUB:  r = INIT_SUB;
      OP_MUL:  r = INIT_MUL;
      default: r = INIT_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_timeout_cnt.sv
// Loadable saturating up-counter with synchronous clear and a
// terminal-count flag; clear has priority over load over count.
module alu_timeout_cnt #(
  parameter int              CW   = 5,
  parameter logic [CW-1:0]   TERM = '1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          en,
  output logic          term
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear, load, or increment while below all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign term = (cnt_q == TERM);

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequencer between switches/button and the ALU datapath: latches
// operands, enables one unit, waits, and registers result for display.
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int W            = 3,
  parameter int MULT_TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   portA,
  input  logic [W-1:0]   portB,
  input  logic [1:0]     opcode,
  input  logic [W:0]     sal_suma,
  input  logic [W:0]     sal_resta,
  input  logic           sresta,
  input  logic [2*W-1:0] sal_mult,
  input  logic           mult_done,
  output logic [W-1:0]   op_a,
  output logic [W-1:0]   op_b,
  output logic [3:0]     init,
  output logic [2*W-1:0] result,
  output logic           signo,
  output logic           busy,
  output logic           done,
  output logic           err
);

  localparam int            CW       = $clog2(MULT_TIMEOUT) + 1;
  localparam logic [CW-1:0] TMO_TERM = CW'(MULT_TIMEOUT - 1);

  state_e         state_q, state_d;
  logic [W-1:0]   op_a_q, op_a_d;
  logic [W-1:0]   op_b_q, op_b_d;
  logic [1:0]     op_q, op_d;
  logic [2*W-1:0] result_q, result_d;
  logic           signo_q, signo_d;
  logic           err_q, err_d;
  logic           tmo_term;

  // Counter only runs while waiting on the multiplier; it is
  // held at zero otherwise so each wait starts from a clean count.
  alu_timeout_cnt #(
    .CW   (CW),
    .TERM (TMO_TERM)
  ) u_tmo (
    .clk      (clk),
    .rst      (rst),
    .clr      (state_q != WAIT_MULT),
    .load     (1'b0),
    .load_val ('0),
    .en       (state_q == WAIT_MULT),
    .term     (tmo_term)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; mult_done beats a simultaneous timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = EXEC;
      EXEC: begin
        unique case (op_q)
          OP_ADD:  state_d = SETTLE;
          OP_SUB:  state_d = SETTLE;
          OP_MUL:  state_d = WAIT_MULT;
          default: state_d = FAULT;
        endcase
      end
      SETTLE: state_d = DONE;
      WAIT_MULT: begin
        if (mult_done)     state_d = DONE;
        else if (tmo_term) state_d = FAULT;
      end
      FAULT:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    init = INIT_NONE;
    busy = (state_q != IDLE);
    done = (state_q == DONE);
    unique case (state_q)
      EXEC:      init = op_to_init(op_q);
      SETTLE:    init = op_to_init(op_q);
      WAIT_MULT: init = INIT_MUL;
      default:   init = INIT_NONE;
    endcase
  end

  // Operand latch and result/sign/error capture.
  always_comb begin
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    op_d     = op_q;
    result_d = result_q;
    signo_d  = signo_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_a_d = portA;
          op_b_d = portB;
          op_d   = opcode;
          err_d  = 1'b0;
        end
      end
      SETTLE: begin
        if (op_q == OP_SUB) begin
          result_d = {{(W-1){1'b0}}, sal_resta};
          signo_d  = sresta;
        end else begin
          result_d = {{(W-1){1'b0}}, sal_suma};
          signo_d  = 1'b0;
        end
      end
      WAIT_MULT: begin
        if (mult_done) begin
          result_d = sal_mult;
          signo_d  = 1'b0;
        end
      end
      FAULT: begin
        result_d = '0;
        signo_d  = 1'b0;
        err_d    = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath-facing registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a_q   <= '0;
      op_b_q   <= '0;
      op_q     <= OP_ADD;
      result_q <= '0;
      signo_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      op_q     <= op_d;
      result_q <= result_d;
      signo_q  <= signo_d;
      err_q    <= err_d;
    end
  end

  assign op_a   = op_a_q;
  assign op_b   = op_b_q;
  assign result = result_q;
  assign signo  = signo_q;
  assign err    = err_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a small datapath model
// and a scoreboard of expected result/sign/err/latency.
module tb_alu_seq_ctrl;

  localparam int W = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [W-1:0]   portA, portB;
  logic [1:0]     opcode;
  logic [W:0]     sal_suma, sal_resta;
  logic           sresta;
  logic [2*W-1:0] sal_mult;
  logic           mult_done;
  logic [W-1:0]   op_a, op_b;
  logic [3:0]     init;
  logic [2*W-1:0] result;
  logic           signo, busy, done, err;

  typedef struct {
    logic [5:0] res;
    logic       sg;
    logic       er;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  alu_seq_ctrl #(.W(W), .MULT_TIMEOUT(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .portA     (portA),
    .portB     (portB),
    .opcode    (opcode),
    .sal_suma  (sal_suma),
    .sal_resta (sal_resta),
    .sresta    (sresta),
    .sal_mult  (sal_mult),
    .mult_done (mult_done),
    .op_a      (op_a),
    .op_b      (op_b),
    .init      (init),
    .result    (result),
    .signo     (signo),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  // Combinational adder/subtractor fed from the latched operands.
  always_comb begin
    sal_suma  = {1'b0, op_a} + {1'b0, op_b};
    sresta    = (op_b > op_a);
    sal_resta = sresta ? ({1'b0, op_b} - {1'b0, op_a})
                       : ({1'b0, op_a} - {1'b0, op_b});
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [2:0] a, input logic [2:0] b,
                       input logic [1:0] op, input exp_t e);
    portA  = a;
    portB  = b;
    opcode = op;
    start  = 1'b1;
    sb.push_back(e);
    tick();
    start  = 1'b0;
  endtask

  // Called in the first cycle after acceptance (latency 1).
  task automatic wait_done(input logic [3:0] exp_init,
                           input int init_until,
                           input int mdone_at,
                           input int restart_at);
    int   lat;
    exp_t e;
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin
      if (lat <= init_until) chk("init", 32'(init), 32'(exp_init));
      chk("busy_run", 32'(busy), 1);
      mult_done = (mdone_at >= 0) && (lat == mdone_at);
      start     = (lat == restart_at);
      tick();
      lat++;
    end
    mult_done = 1'b0;
    start     = 1'b0;
    e = sb.pop_front();
    chk("latency", lat, e.lat);
    chk("result", 32'(result), 32'(e.res));
    chk("signo", 32'(signo), 32'(e.sg));
    chk("err", 32'(err), 32'(e.er));
    chk("init_done", 32'(init), 0);
    tick();
    chk("done_pulse", 32'(done), 0);
    chk("busy_idle", 32'(busy), 0);
  endtask

  initial begin
    int nd;
    rst       = 1'b1;
    start     = 1'b0;
    portA     = '0;
    portB     = '0;
    opcode    = 2'b00;
    sal_mult  = '0;
    mult_done = 1'b0;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_init", 32'(init), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_op_a", 32'(op_a), 0);
    rst = 1'b0;
    tick();

    // Add 3+4
    do_op(3'd3, 3'd4, 2'b00, '{res: 6'd7, sg: 1'b0, er: 1'b0, lat: 3});
    wait_done(4'b0001, 2, -1, -1);
    portA = 3'd1;
    tick();
    tick();
    chk("result_hold", 32'(result), 7);

    // Sub 2-6, switches move while busy
    do_op(3'd2, 3'd6, 2'b01, '{res: 6'd4, sg: 1'b1, er: 1'b0, lat: 3});
    portA = 3'd5;
    portB = 3'd1;
    chk("op_a_hold", 32'(op_a), 2);
    chk("op_b_hold", 32'(op_b), 6);
    wait_done(4'b0010, 2, -1, -1);
    chk("op_a_stable", 32'(op_a), 2);
    chk("op_b_stable", 32'(op_b), 6);

    // Mult 7x7, mult_done after 5 waiting cycles
    sal_mult = 6'd49;
    do_op(3'd7, 3'd7, 2'b10, '{res: 6'd49, sg: 1'b0, er: 1'b0, lat: 8});
    wait_done(4'b0100, 7, 7, -1);

    // Async reset while waiting on the multiplier
    do_op(3'd6, 3'd5, 2'b10, '{res: 6'd0, sg: 1'b0, er: 1'b0, lat: 0});
    sb.delete();
    for (int i = 1; i < 5; i++) tick();
    chk("pre_rst_init", 32'(init), 32'(4'b0100));
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_init", 32'(init), 0);
    chk("arst_result", 32'(result), 0);
    chk("arst_done", 32'(done), 0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_busy", 32'(busy), 0);
    do_op(3'd2, 3'd3, 2'b00, '{res: 6'd5, sg: 1'b0, er: 1'b0, lat: 3});
    wait_done(4'b0001, 2, -1, -1);

    // Multiplier timeout
    do_op(3'd4, 3'd4, 2'b10, '{res: 6'd0, sg: 1'b0, er: 1'b1, lat: 19});
    wait_done(4'b0100, 17, -1, -1);
    tick();
    chk("err_sticky", 32'(err), 1);

    // Next start clears err
    do_op(3'd1, 3'd1, 2'b00, '{res: 6'd2, sg: 1'b0, er: 1'b0, lat: 3});
    chk("err_clear", 32'(err), 0);
    wait_done(4'b0001, 2, -1, -1);

    // Reserved opcode, with a start pulse while busy
    do_op(3'd5, 3'd2, 2'b11, '{res: 6'd0, sg: 1'b0, er: 1'b1, lat: 3});
    opcode = 2'b00;
    wait_done(4'b0000, 2, -1, 1);
    nd = 0;
    for (int i = 0; i < 4; i++) begin
      if (done === 1'b1) nd++;
      tick();
    end
    chk("no_extra_done", nd, 0);
    chk("rsv_result_hold", 32'(result), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
